hazard_scoreboard: RTL and testbench

Tracks destination registers of in-flight instructions between instruction decode and register-file write-back. Raises `hazard` to the decode stage when a source register of the decoding instruction is still pending. The decode stage consumes `hazard` to zero its control outputs and hold its instruction. Sits beside the decode stage, fed by decode-side fields and pipeline-control signals.

---
 rtl/hazard_scoreboard_if.sv | 27 ++
 rtl/hazard_scoreboard.sv | 67 ++++++
 tb/tb_hazard_scoreboard.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: source/dest fields and pipeline control in,
// stall decision, pending-register bitmap and stall counter out.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             src1_used;
    logic             src2_used;
    logic [3:0]       dest;
    logic             wb_en;
    logic             freeze;
    logic             flush;
    logic             hazard;
    logic [15:0]      pending;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output src1, src2, src1_used, src2_used, dest, wb_en, freeze, flush,
        input  hazard, pending, stall_count
    );

    modport slave (
        input  src1, src2, src1_used, src2_used, dest, wb_en, freeze, flush,
        output hazard, pending, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadow pipeline of in-flight destinations; hazard is combinational, an insert is visible the next cycle.
// No backpressure of its own: freeze holds the shadow pipeline, hazard/flush insert a bubble.
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave sb
);

    typedef struct packed {
        logic       vld;
        logic [3:0] dest;
    } entry_t;

    entry_t           shadow_q [DEPTH];
    logic [15:0]      pending;
    logic             hazard;
    logic             issue;
    logic [CNT_W-1:0] stall_cnt_q;

    // A register is pending while any valid entry targets it, WB stage included,
    // so match(x) reduces to a lookup in the bitmap.
    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (shadow_q[k].vld) begin
                pending[shadow_q[k].dest] = 1'b1;
            end
        end
    end

    always_comb begin
        hazard = (sb.src1_used & pending[sb.src1]) |
                 (sb.src2_used & pending[sb.src2]);
        issue  = ~hazard & ~sb.flush & ~sb.freeze;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (!sb.freeze) begin
            shadow_q[0].vld  <= issue & sb.wb_en;
            shadow_q[0].dest <= sb.dest;
            for (int k = 1; k < DEPTH; k++) begin
                shadow_q[k] <= shadow_q[k-1];
            end
        end
    end

    // Counts every hazard cycle, frozen or not, and sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign sb.hazard      = hazard;
    assign sb.pending     = pending;
    assign sb.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard (DEPTH=3, CNT_W=4).
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(CNT_W)) sb_if ();

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s1, input logic s1u, input logic [3:0] s2,
                         input logic s2u, input logic [3:0] d, input logic wb,
                         input logic fz, input logic fl);
        sb_if.src1      = s1;
        sb_if.src1_used = s1u;
        sb_if.src2      = s2;
        sb_if.src2_used = s2u;
        sb_if.dest      = d;
        sb_if.wb_en     = wb;
        sb_if.freeze    = fz;
        sb_if.flush     = fl;
        #2;
    endtask

    task automatic idle();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        check_val("reset_hazard", 32'(sb_if.hazard), 32'd0);
        check_val("reset_pending", 32'(sb_if.pending), 32'd0);
        check_val("reset_stall", 32'(sb_if.stall_count), 32'd0);
        step();
        rst = 1'b1;

        // Async reset with three valid entries and a non-zero counter
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0); step();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0); step();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0); step();
        drive(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_val("three_pending", 32'(sb_if.pending), 32'h0052);
        check_val("frozen_hazard", 32'(sb_if.hazard), 32'd1);
        step();
        check_val("frozen_pending", 32'(sb_if.pending), 32'h0052);
        check_val("frozen_stall", 32'(sb_if.stall_count), 32'd1);
        rst = 1'b0;
        #1;
        check_val("arst_pending", 32'(sb_if.pending), 32'd0);
        check_val("arst_hazard", 32'(sb_if.hazard), 32'd0);
        check_val("arst_stall", 32'(sb_if.stall_count), 32'd0);
        step();
        rst = 1'b1;

        // RAW: producer R2, consumer src1=R2 (writes R9)
        do_reset();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        check_val("raw_prod_hazard", 32'(sb_if.hazard), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(4'd2, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
            check_val($sformatf("raw_hazard_c%0d", i), 32'(sb_if.hazard), 32'd1);
            check_val($sformatf("raw_pending_c%0d", i), 32'(sb_if.pending), 32'h0004);
            step();
        end
        drive(4'd2, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        check_val("raw_release", 32'(sb_if.hazard), 32'd0);
        check_val("raw_stall", 32'(sb_if.stall_count), 32'd3);
        step();
        idle();
        check_val("raw_consumer_issued", 32'(sb_if.pending), 32'h0200);

        // Unused source: producer R5, consumer src2=R5 not read
        do_reset();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0); step();
        drive(4'd0, 1'b1, 4'd5, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        check_val("unused_src_hazard", 32'(sb_if.hazard), 32'd0);
        step();
        idle();
        check_val("unused_src_pending", 32'(sb_if.pending), 32'h0120);

        // Freeze stretches residency: producer R3, two freeze cycles
        do_reset();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0); step();
        for (int i = 0; i < 5; i++) begin
            drive(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, (i < 2) ? 1'b1 : 1'b0, 1'b0);
            check_val($sformatf("frz_hazard_c%0d", i), 32'(sb_if.hazard), 32'd1);
            check_val($sformatf("frz_pend3_c%0d", i), 32'(sb_if.pending[3]), 32'd1);
            step();
        end
        drive(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_val("frz_release", 32'(sb_if.hazard), 32'd0);
        check_val("frz_pend3_clear", 32'(sb_if.pending[3]), 32'd0);
        check_val("frz_stall", 32'(sb_if.stall_count), 32'd5);

        // Flush: older R2 survives, R7 never lands, flush+hazard still counts
        do_reset();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0); step();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
        check_val("flush_pending_a", 32'(sb_if.pending), 32'h0004);
        step();
        drive(4'd2, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
        check_val("flush_pending_b", 32'(sb_if.pending), 32'h0004);
        check_val("flush_hazard", 32'(sb_if.hazard), 32'd1);
        step();
        idle();
        check_val("flush_pending_c", 32'(sb_if.pending), 32'h0004);
        check_val("flush_stall", 32'(sb_if.stall_count), 32'd1);
        step();
        idle();
        check_val("flush_drained", 32'(sb_if.pending), 32'd0);

        // Same dest retiring and inserting on one edge; R15 tracked normally
        do_reset();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0); step();
        idle(); step();
        idle(); step();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0);
        check_val("same_dest_before", 32'(sb_if.pending), 32'h0400);
        step();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
        check_val("same_dest_after", 32'(sb_if.pending), 32'h0400);
        step();
        drive(4'd0, 1'b0, 4'd15, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        check_val("r15_pending", 32'(sb_if.pending), 32'h8400);
        check_val("r15_hazard", 32'(sb_if.hazard), 32'd1);

        // Saturation: hazard held under freeze for 20 cycles
        do_reset();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0); step();
        for (int i = 0; i < 20; i++) begin
            drive(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            if (i == 14) begin
                check_val("sat_count_14", 32'(sb_if.stall_count), 32'd14);
            end
            step();
        end
        drive(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_val("sat_count_20", 32'(sb_if.stall_count), 32'd15);
        check_val("sat_hazard", 32'(sb_if.hazard), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
